// File: rtl/drop_scheduler.sv
// drop_scheduler: central timing controller for the three falling-letter columns.
//   Produces round-robin step pulses on a level-dependent tick, sequences column
//   spawns with a one-outstanding req/ack handshake, ramps the speed level from
//   the score, and freezes play on pause (enable low) or game over.
// Ports:
//   clock        in   system clock
//   reset_signal in   synchronous active-high reset
//   enable       in   game running; low pauses play
//   score[7:0]   in   current score (unsigned)
//   game_over[2:0] in per-column letter reached bottom
//   correct[2:0] in   one-cycle pulse, column letter matched
//   spawn_ack[2:0] in one-cycle pulse, column loaded a new letter
//   step[2:0]    out  one-cycle pulse, advance column ypos
//   spawn_req[2:0] out one-hot request for a column to load a letter
//   active[2:0]  out  column holds a falling letter
//   level[3:0]   out  current speed level
//   halted       out  high in HALT
module drop_scheduler #(
  parameter int unsigned BASE_PERIOD = 25000000,
  parameter int unsigned MIN_PERIOD  = 2500000,
  parameter int unsigned PERIOD_STEP = 1500000,
  parameter int unsigned LEVEL_SCORE = 10,
  parameter int unsigned MAX_LEVEL   = 15,
  parameter int unsigned SPAWN_GAP   = 4
) (
  input  logic       clock,
  input  logic       reset_signal,
  input  logic       enable,
  input  logic [7:0] score,
  input  logic [2:0] game_over,
  input  logic [2:0] correct,
  input  logic [2:0] spawn_ack,
  output logic [2:0] step,
  output logic [2:0] spawn_req,
  output logic [2:0] active,
  output logic [3:0] level,
  output logic       halted
);
  localparam int unsigned GW = (SPAWN_GAP < 1) ? 1 : $clog2(SPAWN_GAP + 1);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, HALT} state_e;

  state_e          state_q, state_d;
  logic [31:0]     tick_cnt_q, tick_cnt_d;
  logic [31:0]     period_q, period_d;
  logic [1:0]      rr_ptr_q, rr_ptr_d;
  logic [GW-1:0]   gap_cnt_q, gap_cnt_d;
  logic [3:0]      level_q, level_d;
  logic [2:0]      step_q, step_d;
  logic [2:0]      req_q, req_d;
  logic [2:0]      active_q, active_d;
  logic            halted_q, halted_d;

  logic            playing, go, tick, acked;
  logic [31:0]     dec, lvl_thresh;
  logic [2:0]      free_col;

  always_comb begin
    // Period is recomputed every cycle from the registered level; the counter
    // compares against it with >=, so a shrink below the count ticks at once.
    dec        = 32'(level_q) * PERIOD_STEP;
    period_d   = (dec + MIN_PERIOD > BASE_PERIOD) ? MIN_PERIOD : BASE_PERIOD - dec;
    lvl_thresh = (32'(level_q) + 32'd1) * LEVEL_SCORE;

    playing = (state_q == RUN) || (state_q == PAUSE);
    go      = playing && (|game_over);
    tick    = (state_q == RUN) && (tick_cnt_q >= period_q - 32'd1);
    acked   = playing && !go && (|(spawn_ack & req_q));

    // Lowest-index inactive column, one-hot.
    if (!active_q[0])      free_col = 3'b001;
    else if (!active_q[1]) free_col = 3'b010;
    else if (!active_q[2]) free_col = 3'b100;
    else                   free_col = 3'b000;

    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    rr_ptr_d   = rr_ptr_q;
    gap_cnt_d  = gap_cnt_q;
    level_d    = level_q;
    step_d     = 3'b000;
    req_d      = req_q;
    active_d   = active_q;

    case (state_q)
      IDLE: if (enable) state_d = RUN;
      RUN, PAUSE: begin
        if (go) begin
          // Game over wins over everything else in the cycle.
          state_d = HALT;
          req_d   = 3'b000;
        end else begin
          if (state_q == RUN) begin
            if (!enable) state_d = PAUSE;
            if (level_q < 4'(MAX_LEVEL) && 32'(score) >= lvl_thresh)
              level_d = level_q + 4'd1;
            if (tick) begin
              tick_cnt_d = 32'd0;
              step_d     = 3'(3'b001 << rr_ptr_q) & active_q & ~correct;
              rr_ptr_d   = (rr_ptr_q == 2'd2) ? 2'd0 : rr_ptr_q + 2'd1;
              if (gap_cnt_q != GW'(SPAWN_GAP)) gap_cnt_d = gap_cnt_q + 1'b1;
            end else begin
              tick_cnt_d = tick_cnt_q + 32'd1;
            end
            if (gap_cnt_q == GW'(SPAWN_GAP) && req_q == 3'b000)
              req_d = free_col;
          end else if (enable) begin
            state_d = RUN;
          end
          active_d = active_q & ~correct;
          if (acked) begin
            active_d  = active_d | req_q;
            req_d     = 3'b000;
            gap_cnt_d = '0;
          end
        end
      end
      default: req_d = 3'b000;  // HALT
    endcase

    halted_d = (state_d == HALT);
  end

  always_ff @(posedge clock) begin
    if (reset_signal) begin
      state_q    <= IDLE;
      tick_cnt_q <= 32'd0;
      period_q   <= BASE_PERIOD;
      rr_ptr_q   <= 2'd0;
      gap_cnt_q  <= GW'(SPAWN_GAP);  // first spawn is immediate
      level_q    <= 4'd0;
      step_q     <= 3'b000;
      req_q      <= 3'b000;
      active_q   <= 3'b000;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      period_q   <= period_d;
      rr_ptr_q   <= rr_ptr_d;
      gap_cnt_q  <= gap_cnt_d;
      level_q    <= level_d;
      step_q     <= step_d;
      req_q      <= req_d;
      active_q   <= active_d;
      halted_q   <= halted_d;
    end
  end

  assign step      = step_q;
  assign spawn_req = req_q;
  assign active    = active_q;
  assign level     = level_q;
  assign halted    = halted_q;
endmodule

// File: tb/tb_drop_scheduler.sv
// Self-checking bench for drop_scheduler: directed scenarios plus a random
// phase, every cycle compared against a behavioural model of the scheduler.
module tb_drop_scheduler;
  localparam int BASE = 8, MINP = 2, PSTEP = 2, LSC = 10, MAXL = 15, GAP = 2;
  localparam int S_IDLE = 0, S_RUN = 1, S_PAUSE = 2, S_HALT = 3;

  logic       clock = 1'b0;
  logic       reset_signal = 1'b1, enable = 1'b0;
  logic [7:0] score = 8'd0;
  logic [2:0] game_over = 3'b000, correct = 3'b000, spawn_ack = 3'b000;
  logic [2:0] step, spawn_req, active;
  logic [3:0] level;
  logic       halted;

  int tests = 0, fails = 0;
  int step_cnt;
  string phase = "init";

  // behavioural model state
  int m_state = S_IDLE, m_cnt = 0, m_period = BASE, m_rr = 0, m_gap = GAP;
  int m_level = 0, m_req = -1, m_step = -1;
  bit m_act [3] = '{0, 0, 0};

  drop_scheduler #(
    .BASE_PERIOD(BASE), .MIN_PERIOD(MINP), .PERIOD_STEP(PSTEP),
    .LEVEL_SCORE(LSC), .MAX_LEVEL(MAXL), .SPAWN_GAP(GAP)
  ) dut (
    .clock(clock), .reset_signal(reset_signal), .enable(enable), .score(score),
    .game_over(game_over), .correct(correct), .spawn_ack(spawn_ack),
    .step(step), .spawn_req(spawn_req), .active(active), .level(level),
    .halted(halted)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Next model state from the current inputs, as the rules describe it.
  task automatic model_update();
    int ns, nc, np, nr, ng, nl, nq, nst;
    bit na [3];
    if (reset_signal) begin
      m_state = S_IDLE; m_cnt = 0; m_period = BASE; m_rr = 0; m_gap = GAP;
      m_level = 0; m_req = -1; m_step = -1; m_act = '{0, 0, 0};
      return;
    end
    ns = m_state; nc = m_cnt; nr = m_rr; ng = m_gap; nl = m_level;
    nq = m_req; nst = -1; na = m_act;
    np = BASE - m_level * PSTEP;
    if (np < MINP) np = MINP;
    if (m_state == S_IDLE) begin
      if (enable) ns = S_RUN;
    end else if (m_state == S_HALT) begin
      nq = -1;
    end else if (game_over != 3'b000) begin
      ns = S_HALT; nq = -1;
    end else begin
      if (m_state == S_RUN) begin
        if (!enable) ns = S_PAUSE;
        if (m_level < MAXL && int'(score) >= (m_level + 1) * LSC) nl = m_level + 1;
        if (m_cnt >= m_period - 1) begin
          nc = 0;
          if (m_act[m_rr] && !correct[m_rr]) nst = m_rr;
          nr = (m_rr + 1) % 3;
          if (m_gap < GAP) ng = m_gap + 1;
        end else nc = m_cnt + 1;
        if (m_gap == GAP && m_req < 0)
          for (int i = 2; i >= 0; i--) if (!m_act[i]) nq = i;
      end else if (enable) ns = S_RUN;
      for (int i = 0; i < 3; i++) if (correct[i]) na[i] = 0;
      if (m_req >= 0 && spawn_ack[m_req]) begin
        na[m_req] = 1; nq = -1; ng = 0;
      end
    end
    m_state = ns; m_cnt = nc; m_period = np; m_rr = nr; m_gap = ng;
    m_level = nl; m_req = nq; m_step = nst; m_act = na;
  endtask

  task automatic check_outputs();
    logic [2:0] e_step, e_req, e_act;
    e_step = (m_step >= 0) ? 3'(1 << m_step) : 3'b000;
    e_req  = (m_req >= 0) ? 3'(1 << m_req) : 3'b000;
    e_act  = {m_act[2], m_act[1], m_act[0]};
    chk({phase, ".step"}, 32'(step), 32'(e_step));
    chk({phase, ".req"}, 32'(spawn_req), 32'(e_req));
    chk({phase, ".active"}, 32'(active), 32'(e_act));
    chk({phase, ".level"}, 32'(level), 32'(m_level));
    chk({phase, ".halted"}, 32'(halted), 32'(m_state == S_HALT));
  endtask

  task automatic cyc();
    model_update();
    @(posedge clock);
    #1;
    check_outputs();
  endtask

  task automatic wait_req(input logic [2:0] want, input int limit, input string tag);
    for (int i = 0; i < limit; i++) begin
      if (spawn_req === want) break;
      cyc();
    end
    chk(tag, 32'(spawn_req), 32'(want));
  endtask

  task automatic ack(input logic [2:0] col);
    spawn_ack = col;
    cyc();
    spawn_ack = 3'b000;
  endtask

  initial begin
    // reset state
    phase = "reset";
    reset_signal = 1'b1;
    cyc(); cyc();
    chk("rst.step", 32'(step), 0);
    chk("rst.req", 32'(spawn_req), 0);
    chk("rst.level", 32'(level), 0);
    reset_signal = 1'b0;

    // first spawn immediate, next only after SPAWN_GAP ticks
    phase = "t1";
    enable = 1'b1;
    cyc(); cyc();
    chk("t1.first_req", 32'(spawn_req), 32'h1);
    ack(3'b001);
    chk("t1.active", 32'(active), 32'h1);
    for (int i = 0; i < 8; i++) begin
      cyc();
      chk("t1.gap_hold", 32'(spawn_req), 0);
    end
    wait_req(3'b010, 20, "t1.req1");
    ack(3'b010);
    wait_req(3'b100, 24, "t1.req2");
    repeat ($urandom_range(0, 3)) cyc();
    ack(3'b100);
    chk("t1.all_active", 32'(active), 32'h7);

    // round-robin steps at period 8
    phase = "t2";
    step_cnt = 0;
    repeat (48) begin
      cyc();
      chk("t2.onehot", 32'($countones(step) <= 1), 1);
      if (step != 3'b000) step_cnt++;
    end
    chk("t2.steps", 32'(step_cnt), 6);

    // level ramps one per cycle, period floors
    phase = "t3";
    score = 8'd35;
    cyc(); chk("t3.lvl1", 32'(level), 1);
    cyc(); chk("t3.lvl2", 32'(level), 2);
    cyc(); chk("t3.lvl3", 32'(level), 3);
    cyc(); chk("t3.lvl3hold", 32'(level), 3);
    repeat (4) cyc();
    step_cnt = 0;
    repeat (12) begin cyc(); if (step != 3'b000) step_cnt++; end
    chk("t3.steps_p2", 32'(step_cnt), 6);
    score = 8'd80;
    repeat (10) cyc();
    chk("t3.lvl8", 32'(level), 8);
    step_cnt = 0;
    repeat (12) begin cyc(); if (step != 3'b000) step_cnt++; end
    chk("t3.steps_floor", 32'(step_cnt), 6);

    // correct on col1's step cycle suppresses the step
    phase = "t4";
    for (int i = 0; i < 20; i++) begin
      if (m_state == S_RUN && m_cnt >= m_period - 1 && m_rr == 1) break;
      cyc();
    end
    correct = 3'b010;
    cyc();
    correct = 3'b000;
    chk("t4.step1", 32'(step[1]), 0);
    chk("t4.active1", 32'(active[1]), 0);
    wait_req(3'b010, 20, "t4.rereq");
    ack(3'b010);

    // pause with an outstanding request
    phase = "t5";
    correct = 3'b001;
    cyc();
    correct = 3'b000;
    wait_req(3'b001, 20, "t5.req");
    enable = 1'b0;
    cyc();
    repeat (10) begin
      cyc();
      chk("t5.nostep", 32'(step), 0);
      chk("t5.reqheld", 32'(spawn_req), 32'h1);
    end
    ack(3'b001);
    chk("t5.ackpause", 32'(active[0]), 1);
    enable = 1'b1;
    repeat (10) cyc();

    // random traffic
    phase = "rand";
    repeat (1500) begin
      enable       = ($urandom_range(0, 15) != 0);
      reset_signal = ($urandom_range(0, 299) == 0);
      if (reset_signal) score = 8'd0;
      else if ($urandom_range(0, 3) == 0 && score != 8'hff) score = score + 8'd1;
      correct   = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
      spawn_ack = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
      cyc();
    end
    reset_signal = 1'b0; correct = 3'b000; spawn_ack = 3'b000;

    // game over while a request is outstanding
    phase = "t6";
    reset_signal = 1'b1; score = 8'd0; enable = 1'b0;
    cyc();
    reset_signal = 1'b0; enable = 1'b1;
    cyc(); cyc();
    chk("t6.req", 32'(spawn_req), 32'h1);
    game_over = 3'b100;
    cyc();
    game_over = 3'b000;
    chk("t6.halted", 32'(halted), 1);
    chk("t6.reqdrop", 32'(spawn_req), 0);
    repeat (20) begin
      correct   = 3'($urandom_range(0, 7));
      spawn_ack = 3'($urandom_range(0, 7));
      enable    = 1'($urandom_range(0, 1));
      cyc();
      chk("t6.halt_step", 32'(step), 0);
      chk("t6.halt_req", 32'(spawn_req), 0);
    end
    correct = 3'b000; spawn_ack = 3'b000; enable = 1'b0;
    reset_signal = 1'b1;
    cyc();
    reset_signal = 1'b0;
    chk("t6.rst_out", 32'({step, spawn_req, active, level, halted}), 0);
    cyc();
    chk("t6.idle_req", 32'(spawn_req), 0);

    // game over and correct together: active untouched
    phase = "t7";
    enable = 1'b1;
    wait_req(3'b001, 6, "t7.req");
    ack(3'b001);
    game_over = 3'b010; correct = 3'b001;
    cyc();
    game_over = 3'b000; correct = 3'b000;
    chk("t7.active", 32'(active), 32'h1);
    chk("t7.halted", 32'(halted), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
